// File: rtl/raman_channel_sequencer_pkg.sv
// Shared definitions for the Raman channel sequencer: legacy channel codes,
// FSM state encoding and the channel-index width helper.
package raman_channel_sequencer_pkg;

  localparam int unsigned CH_ANTISTOKES = 0;
  localparam int unsigned CH_STOKES     = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2
  } state_e;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raman_channel_sequencer_if.sv
// Bus between acquisition counters / host and the channel sequencer.
// master drives counters, enable and force requests; slave is the sequencer.
interface raman_channel_sequencer_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned MW  = 17,
  parameter int unsigned PW  = 11
);
  localparam int unsigned CHW = raman_channel_sequencer_pkg::idx_width(NCH);

  logic           enable;
  logic [MW-1:0]  cnt_measure;
  logic [PW-1:0]  cnt_point;
  logic [MW-1:0]  measures;
  logic [PW-1:0]  sw_point;
  logic           force_req;
  logic [CHW-1:0] force_ch;
  logic           force_ack;
  logic [CHW-1:0] ch_sel;
  logic [NCH-1:0] ch_onehot;
  logic           settling;
  logic           ch_done;
  logic           sweep_done;
  logic           missed_trig;

  modport master (
    output enable, cnt_measure, cnt_point, measures, sw_point, force_req, force_ch,
    input  force_ack, ch_sel, ch_onehot, settling, ch_done, sweep_done, missed_trig
  );

  modport slave (
    input  enable, cnt_measure, cnt_point, measures, sw_point, force_req, force_ch,
    output force_ack, ch_sel, ch_onehot, settling, ch_done, sweep_done, missed_trig
  );

endinterface

// File: rtl/raman_channel_sequencer_settle_timer.sv
// Loadable down-counter timing the post-switch blanking window.
// done is high while the count is zero; load starts a SETTLE_CYC-long window.
module raman_channel_sequencer_settle_timer #(
  parameter int unsigned SETTLE_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  output logic done
);
  localparam int unsigned CW    = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int unsigned LOADV = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt_c;

  always_comb begin
    cnt_nxt_c = cnt;
    if (clear) begin
      cnt_nxt_c = '0;
    end else if (load) begin
      cnt_nxt_c = CW'(LOADV);
    end else if (cnt != '0) begin
      cnt_nxt_c = cnt - CW'(1);
    end
  end

  // done registered from the next count so it tracks cnt == 0 without a comb output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b1;
    end else begin
      cnt  <= cnt_nxt_c;
      done <= (cnt_nxt_c == '0);
    end
  end

endmodule

// File: rtl/raman_channel_sequencer.sv
// Steps the optical channel selector once per completed accumulation block,
// with post-switch blanking, edge-qualified triggering and a host force handshake.
module raman_channel_sequencer
  import raman_channel_sequencer_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned MW         = 17,
  parameter int unsigned PW         = 11,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned START_CH   = CH_ANTISTOKES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  raman_channel_sequencer_if.slave   bus
);
  localparam int unsigned    CHW       = idx_width(NCH);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);
  localparam logic [CHW-1:0] RST_CH    = CHW'(START_CH);
  localparam bit             SETTLE_EN = (SETTLE_CYC != 0);

  state_e         state;
  logic           match_q;
  logic           match_c;
  logic           trig_c;
  logic           force_ok_c;
  logic           switch_c;
  logic [CHW-1:0] adv_ch_c;
  logic           timer_load_c;
  logic           timer_clear_c;
  logic           settle_done;

  function automatic logic [NCH-1:0] decode(input logic [CHW-1:0] ch);
    return NCH'(1) << ch;
  endfunction

  // measures == 0 is excluded explicitly since measures-1 would wrap to all ones
  always_comb begin
    match_c       = (bus.measures != '0)
                 && (bus.cnt_measure == bus.measures - MW'(1))
                 && (bus.cnt_point == PW'(bus.sw_point));
    trig_c        = match_c && !match_q;
    adv_ch_c      = (bus.ch_sel == LAST_CH) ? '0 : bus.ch_sel + CHW'(1);
    force_ok_c    = (32'(bus.force_ch) < NCH);
    switch_c      = (state == S_RUN) && bus.enable
                 && (trig_c || (bus.force_req && force_ok_c));
    timer_load_c  = switch_c && SETTLE_EN;
    timer_clear_c = !bus.enable;
  end

  raman_channel_sequencer_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear_c),
    .load  (timer_load_c),
    .done  (settle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      match_q         <= 1'b0;
      bus.ch_sel      <= RST_CH;
      bus.ch_onehot   <= decode(RST_CH);
      bus.settling    <= 1'b0;
      bus.ch_done     <= 1'b0;
      bus.sweep_done  <= 1'b0;
      bus.force_ack   <= 1'b0;
      bus.missed_trig <= 1'b0;
    end else begin
      match_q        <= match_c;
      bus.force_ack  <= 1'b0;
      bus.ch_done    <= 1'b0;
      bus.sweep_done <= 1'b0;
      if (!bus.enable) begin
        state        <= S_IDLE;
        bus.settling <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state           <= S_RUN;
            bus.missed_trig <= 1'b0;
          end
          // trigger wins over a simultaneous force; the force stays pending
          S_RUN: begin
            if (trig_c) begin
              bus.ch_sel     <= adv_ch_c;
              bus.ch_onehot  <= decode(adv_ch_c);
              bus.ch_done    <= 1'b1;
              bus.sweep_done <= (bus.ch_sel == LAST_CH);
              if (SETTLE_EN) begin
                state        <= S_SETTLE;
                bus.settling <= 1'b1;
              end
            end else if (bus.force_req) begin
              bus.force_ack <= 1'b1;
              if (force_ok_c) begin
                bus.ch_sel    <= bus.force_ch;
                bus.ch_onehot <= decode(bus.force_ch);
                if (SETTLE_EN) begin
                  state        <= S_SETTLE;
                  bus.settling <= 1'b1;
                end
              end
            end
          end
          S_SETTLE: begin
            if (trig_c) begin
              bus.missed_trig <= 1'b1;
            end
            if (settle_done) begin
              state        <= S_RUN;
              bus.settling <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_raman_channel_sequencer.sv
// Bench for raman_channel_sequencer: three parameterisations driven from shared
// counters, compared every cycle against a behavioural model plus literal checks.
module tb_raman_channel_sequencer;
  import raman_channel_sequencer_pkg::*;

  localparam int unsigned MW = 17;
  localparam int unsigned PW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en;
  logic [MW-1:0] cm, meas;
  logic [PW-1:0] cp, swp, npts;
  logic [2:0]    fch;
  logic [2:0]    fr;
  bit            cnt_run;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  raman_channel_sequencer_if #(.NCH(2), .MW(MW), .PW(PW)) if0 ();
  raman_channel_sequencer_if #(.NCH(4), .MW(MW), .PW(PW)) if1 ();
  raman_channel_sequencer_if #(.NCH(5), .MW(MW), .PW(PW)) if2 ();

  assign if0.enable = en;  assign if1.enable = en;  assign if2.enable = en;
  assign if0.cnt_measure = cm;  assign if1.cnt_measure = cm;  assign if2.cnt_measure = cm;
  assign if0.cnt_point = cp;  assign if1.cnt_point = cp;  assign if2.cnt_point = cp;
  assign if0.measures = meas;  assign if1.measures = meas;  assign if2.measures = meas;
  assign if0.sw_point = swp;  assign if1.sw_point = swp;  assign if2.sw_point = swp;
  assign if0.force_req = fr[0];  assign if1.force_req = fr[1];  assign if2.force_req = fr[2];
  assign if0.force_ch = fch[0:0];  assign if1.force_ch = fch[1:0];  assign if2.force_ch = fch;

  raman_channel_sequencer #(.NCH(2), .MW(MW), .PW(PW), .SETTLE_CYC(0), .START_CH(0))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  raman_channel_sequencer #(.NCH(4), .MW(MW), .PW(PW), .SETTLE_CYC(8), .START_CH(0))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  raman_channel_sequencer #(.NCH(5), .MW(MW), .PW(PW), .SETTLE_CYC(3), .START_CH(0))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // behavioural model: "running" flag plus remaining blanking cycles per instance
  int m_ch[3];
  int m_blank[3];
  bit m_run[3], m_missed[3], m_ack[3], m_done[3], m_sweep[3];
  bit m_prev;

  function automatic int nch_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 4 : 5;
  endfunction
  function automatic int settle_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 8 : 3;
  endfunction
  function automatic int mask_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 7;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ch[i] = 0; m_blank[i] = 0; m_run[i] = 0; m_missed[i] = 0;
      m_ack[i] = 0; m_done[i] = 0; m_sweep[i] = 0;
    end
    m_prev = 0;
  endfunction

  function automatic void model_step();
    bit m, t;
    int f;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m = (meas != 0) && (cm == meas - 17'd1) && (cp == swp);
    t = m && !m_prev;
    m_prev = m;
    for (int i = 0; i < 3; i++) begin
      m_ack[i] = 0; m_done[i] = 0; m_sweep[i] = 0;
      if (!en) begin
        m_run[i] = 0; m_blank[i] = 0;
      end else if (!m_run[i]) begin
        m_run[i] = 1; m_missed[i] = 0;
      end else if (m_blank[i] > 0) begin
        if (t) m_missed[i] = 1;
        m_blank[i]--;
      end else if (t) begin
        m_ch[i]    = (m_ch[i] + 1) % nch_of(i);
        m_done[i]  = 1;
        m_sweep[i] = (m_ch[i] == 0);
        m_blank[i] = settle_of(i);
      end else if (fr[i]) begin
        m_ack[i] = 1;
        f = int'(fch) & mask_of(i);
        if (f < nch_of(i)) begin
          m_ch[i]    = f;
          m_blank[i] = settle_of(i);
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s u%0d cyc=%0d: got %0d, expected %0d", name, idx, cyc, act, exp);
  endtask

  task automatic compare_one(input int i, input int ch, input int oh, input int st,
                             input int dn, input int sw, input int ak, input int ms);
    chk("ch_sel", i, ch, m_ch[i]);
    chk("ch_onehot", i, oh, 1 << m_ch[i]);
    chk("settling", i, st, int'(m_blank[i] > 0));
    chk("ch_done", i, dn, int'(m_done[i]));
    chk("sweep_done", i, sw, int'(m_sweep[i]));
    chk("force_ack", i, ak, int'(m_ack[i]));
    chk("missed_trig", i, ms, int'(m_missed[i]));
  endtask

  task automatic compare_all();
    compare_one(0, int'(if0.ch_sel), int'(if0.ch_onehot), int'(if0.settling), int'(if0.ch_done),
                int'(if0.sweep_done), int'(if0.force_ack), int'(if0.missed_trig));
    compare_one(1, int'(if1.ch_sel), int'(if1.ch_onehot), int'(if1.settling), int'(if1.ch_done),
                int'(if1.sweep_done), int'(if1.force_ack), int'(if1.missed_trig));
    compare_one(2, int'(if2.ch_sel), int'(if2.ch_onehot), int'(if2.settling), int'(if2.ch_done),
                int'(if2.sweep_done), int'(if2.force_ack), int'(if2.missed_trig));
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge, then
  // the host drops acknowledged requests and the acquisition counters move on
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    cyc++;
    for (int i = 0; i < 3; i++) if (m_ack[i]) fr[i] = 1'b0;
    if (cnt_run) begin
      if (cp >= npts - 11'd1) begin
        cp = '0;
        cm = (cm + 17'd1 >= meas) ? '0 : cm + 17'd1;
      end else begin
        cp = cp + 11'd1;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n0d, n0s, n1d, n1s;
    bit seen;
    en = 0; cm = 0; cp = 0; meas = 4; swp = 2; npts = 5; fch = 0; fr = 0; cnt_run = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_ch_sel", 1, int'(if1.ch_sel), 0);
    chk("rst_onehot", 1, int'(if1.ch_onehot), 1);
    chk("rst_settling", 1, int'(if1.settling), 0);
    rst_n = 1;

    // counters sweeping: first advance, blanking width, four blocks
    en = 1; cnt_run = 1; seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (if0.ch_done) begin seen = 1; break; end
    end
    chk("first_adv_seen", 0, int'(seen), 1);
    chk("adv_ch_sel", 0, int'(if0.ch_sel), 1);
    chk("adv_ch_sel", 1, int'(if1.ch_sel), 1);
    chk("adv_onehot", 1, int'(if1.ch_onehot), 2);
    chk("adv_no_sweep", 0, int'(if0.sweep_done), 0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (!if1.settling) break;
      n++;
      tick();
    end
    chk("settle_len", 1, n, 8);
    n0d = 0; n0s = 0; n1d = 0; n1s = 0;
    repeat (80) begin
      tick();
      n0d += int'(if0.ch_done); n0s += int'(if0.sweep_done);
      n1d += int'(if1.ch_done); n1s += int'(if1.sweep_done);
    end
    chk("blocks_done", 0, n0d, 4);
    chk("blocks_sweep", 0, n0s, 2);
    chk("blocks_done", 1, n1d, 4);
    chk("blocks_sweep", 1, n1s, 1);

    // stalled counter holding the match fires once
    cnt_run = 0; cm = 0; cp = 0;
    repeat (12) tick();
    cm = 3; cp = 2; n = 0;
    repeat (20) begin tick(); n += int'(if1.ch_done); end
    chk("stall_single_adv", 1, n, 1);
    chk("stall_no_miss", 1, int'(if1.missed_trig), 0);

    // retrigger inside the blanking window
    meas = 1; swp = 0; npts = 3; cm = 0; cp = 1; cnt_run = 1;
    repeat (12) tick();
    chk("missed_set", 1, int'(if1.missed_trig), 1);
    chk("missed_never", 0, int'(if0.missed_trig), 0);
    cnt_run = 0; cp = 1; en = 0;
    tick();
    chk("missed_held_idle", 1, int'(if1.missed_trig), 1);
    en = 1;
    tick();
    chk("missed_cleared", 1, int'(if1.missed_trig), 0);

    // host force: in-range, out-of-range, colliding with a trigger
    repeat (10) tick();
    fch = 3; fr = 3'b111;
    tick();
    chk("force_ack", 1, int'(if1.force_ack), 1);
    chk("force_ch_sel", 1, int'(if1.ch_sel), 3);
    chk("force_settle", 1, int'(if1.settling), 1);
    repeat (12) tick();
    fch = 5; fr = 3'b100;
    tick();
    chk("oor_ack", 2, int'(if2.force_ack), 1);
    chk("oor_ch_kept", 2, int'(if2.ch_sel), 3);
    chk("oor_no_settle", 2, int'(if2.settling), 0);
    repeat (4) tick();
    meas = 4; swp = 2; cm = 3; cp = 2; fch = 0; fr = 3'b111;
    tick();
    chk("collide_adv", 1, int'(if1.ch_done), 1);
    chk("collide_no_ack", 1, int'(if1.force_ack), 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (if1.force_ack) break;
    end
    chk("force_after_settle", 1, n, 9);
    chk("force_after_ch", 1, int'(if1.ch_sel), 0);
    repeat (10) tick();

    // asynchronous reset in the middle of blanking
    cm = 0; cp = 0;
    tick();
    cm = 3; cp = 2;
    tick();
    repeat (3) tick();
    chk("pre_rst_settling", 1, int'(if1.settling), 1);
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_ch", 1, int'(if1.ch_sel), 0);
    chk("async_rst_settling", 1, int'(if1.settling), 0);
    chk("async_rst_done", 1, int'(if1.ch_done), 0);
    repeat (2) tick();
    rst_n = 1;

    // randomized segments
    for (int seg = 0; seg < 12; seg++) begin
      meas = MW'($urandom_range(0, 5));
      swp  = PW'($urandom_range(0, 4));
      npts = PW'($urandom_range(2, 6));
      cm = 0; cp = 0;
      repeat (200) begin
        rst_n = 1'b1;
        if (en && $urandom_range(0, 49) == 0) en = 0;
        else if (!en && $urandom_range(0, 4) == 0) en = 1;
        cnt_run = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 39) == 0) cp = PW'($urandom_range(0, 6));
        if (fr == 3'b000 && $urandom_range(0, 29) == 0) begin
          fch = 3'($urandom_range(0, 7));
          fr  = 3'b111;
        end
        if ($urandom_range(0, 399) == 0) begin
          rst_n = 1'b0;
          #1;
          model_reset();
          compare_all();
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
